arm_regfile_2w: RTL and testbench

- Parametrised successor to the 16x32 single-write register file.
- Provides NUM_REGS registers of DATA_W bits, RD_PORTS asynchronous read ports and two write ports, with defined write-port priority.
- Holds the PC as a dedicated register with an auto-increment path.
- Sits between the decode stage and the execute/writeback stages of the ARM datapath:
  - Write port 0 carries the ALU/load result.
  - Write port 1 carries base-register writeback.

---
 rtl/arm_regfile_pkg.sv | 40 ++++
 rtl/arm_reg_cell.sv | 26 ++
 rtl/arm_regfile_2w.sv | 90 +++++++++
 tb/tb_arm_regfile_2w.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/arm_regfile_pkg.sv
// Shared definitions for arm_regfile_2w: default sizes and the per-register write-select
// resolution (port 0 over port 1 over PC increment).
package arm_regfile_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 16;
  localparam int DEFAULT_RD_PORTS = 3;
  localparam int PC_STEP          = 4;

  typedef enum logic [1:0] {
    SEL_HOLD = 2'd0,
    SEL_WR0  = 2'd1,
    SEL_WR1  = 2'd2,
    SEL_INC  = 2'd3
  } wr_sel_e;

  typedef struct packed {
    logic    ld;
    wr_sel_e sel;
  } wr_res_t;

  // Resolves which source loads a register; the caller turns sel into the next value.
  function automatic wr_res_t resolve_write(input logic hit0, input logic hit1, input logic inc);
    wr_res_t res;
    res.ld  = 1'b1;
    res.sel = SEL_HOLD;
    if (hit0) begin
      res.sel = SEL_WR0;
    end else if (hit1) begin
      res.sel = SEL_WR1;
    end else if (inc) begin
      res.sel = SEL_INC;
    end else begin
      res.sel = SEL_HOLD;
      res.ld  = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/arm_reg_cell.sv
// arm_reg_cell: one DATA_W-bit architectural register with load enable and
// synchronous active-low clear.
module arm_reg_cell #(
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              ld,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] q_r;

  // Register state: clear dominates load
  always_ff @(posedge Clk) begin
    if (!Clr) begin
      q_r <= '0;
    end else if (ld) begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/arm_regfile_2w.sv
// arm_regfile_2w: NUM_REGS x DATA_W register file, RD_PORTS combinational reads, two prioritised
// write ports and an auto-incrementing PC. Define ARM_REGFILE_BYPASS_EN for same-cycle write bypass.
module arm_regfile_2w
  import arm_regfile_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int RD_PORTS = DEFAULT_RD_PORTS,
  parameter int PC_IDX   = NUM_REGS - 1,
  parameter int PC_STEP  = arm_regfile_pkg::PC_STEP
) (
  input  logic                       Clk,
  input  logic                       Clr,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  input  logic                       pc_inc,
  input  logic [RD_PORTS*ADDR_W-1:0] rd_addr,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0]          pc_out
);

  logic [DATA_W-1:0]   regs_s [NUM_REGS];
  logic [DATA_W-1:0]   nxt_s  [NUM_REGS];
  logic [NUM_REGS-1:0] ld_s;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic              hit0_s;
    logic              hit1_s;
    logic              inc_s;
    wr_res_t           res_s;
    logic [DATA_W-1:0] d_s;

    assign hit0_s  = wr0_en && (wr0_addr == ADDR_W'(i));
    assign hit1_s  = wr1_en && (wr1_addr == ADDR_W'(i));
    assign inc_s   = (i == PC_IDX) ? pc_inc : 1'b0;
    assign res_s   = resolve_write(hit0_s, hit1_s, inc_s);
    assign ld_s[i] = res_s.ld;

    // Next-value mux for this register; the increment path only ever selects on the PC
    always_comb begin
      d_s = regs_s[i];
      case (res_s.sel)
        SEL_WR0:  d_s = wr0_data;
        SEL_WR1:  d_s = wr1_data;
        SEL_INC:  d_s = regs_s[i] + DATA_W'(PC_STEP);
        SEL_HOLD: d_s = regs_s[i];
        default:  d_s = regs_s[i];
      endcase
    end

    assign nxt_s[i] = d_s;

    arm_reg_cell #(.DATA_W(DATA_W)) u_cell (
      .Clk (Clk),
      .Clr (Clr),
      .ld  (ld_s[i]),
      .d   (nxt_s[i]),
      .q   (regs_s[i])
    );
  end

  for (genvar k = 0; k < RD_PORTS; k++) begin : g_rd
    logic [ADDR_W-1:0] ra_s;
    logic [DATA_W-1:0] rv_s;

    assign ra_s = rd_addr[k*ADDR_W +: ADDR_W];

    // Read mux; with bypass, a pending (non-reset) load forwards its resolved value
    always_comb begin
      rv_s = regs_s[ra_s];
`ifdef ARM_REGFILE_BYPASS_EN
      if (Clr && ld_s[ra_s]) begin
        rv_s = nxt_s[ra_s];
      end else begin
        rv_s = regs_s[ra_s];
      end
`endif
    end

    assign rd_data[k*DATA_W +: DATA_W] = rv_s;
  end

  assign pc_out = regs_s[PC_IDX];

endmodule

// File: tb/tb_arm_regfile_2w.sv
// Self-checking bench for arm_regfile_2w: directed plan followed by random traffic checked
// against an array model; expectations follow ARM_REGFILE_BYPASS_EN when it is defined.
module tb_arm_regfile_2w;

  localparam int DW  = 32;
  localparam int NR  = 16;
  localparam int AW  = 4;
  localparam int RP  = 3;
  localparam int PCI = 15;
`ifdef ARM_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             Clk = 1'b0;
  logic             Clr;
  logic             wr0_en, wr1_en, pc_inc;
  logic [AW-1:0]    wr0_addr, wr1_addr;
  logic [DW-1:0]    wr0_data, wr1_data;
  logic [RP*AW-1:0] rd_addr;
  logic [RP*DW-1:0] rd_data;
  logic [DW-1:0]    pc_out;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mdl   [NR];
  logic [DW-1:0] nxt_m [NR];

  arm_regfile_2w dut (
    .Clk(Clk), .Clr(Clr),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .pc_inc(pc_inc), .rd_addr(rd_addr), .rd_data(rd_data), .pc_out(pc_out)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural next state: later assignments override earlier ones, giving wr0 > wr1 > pc_inc.
  function automatic void calc_next();
    for (int i = 0; i < NR; i++) nxt_m[i] = Clr ? mdl[i] : '0;
    if (Clr) begin
      if (pc_inc) nxt_m[PCI] = mdl[PCI] + 32'd4;
      if (wr1_en) nxt_m[wr1_addr] = wr1_data;
      if (wr0_en) nxt_m[wr0_addr] = wr0_data;
    end
  endfunction

  task automatic idle();
    Clr = 1'b1; wr0_en = 1'b0; wr1_en = 1'b0; pc_inc = 1'b0;
  endtask

  // One clock of stimulus: same-cycle read check, edge, then post-edge read check with writes idle.
  task automatic step(input logic clr, input logic e0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic e1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic inc, input logic [RP*AW-1:0] ra);
    logic [AW-1:0] a;
    @(negedge Clk);
    Clr = clr; wr0_en = e0; wr0_addr = a0; wr0_data = d0;
    wr1_en = e1; wr1_addr = a1; wr1_data = d1; pc_inc = inc; rd_addr = ra;
    #1;
    calc_next();
    for (int k = 0; k < RP; k++) begin
      a = ra[k*AW +: AW];
      chk("rd_same_cycle", rd_data[k*DW +: DW], (BYP && clr) ? nxt_m[a] : mdl[a]);
    end
    chk("pc_same_cycle", pc_out, mdl[PCI]);
    @(posedge Clk);
    mdl = nxt_m;
    #1;
    idle();
    #1;
    for (int k = 0; k < RP; k++) begin
      a = ra[k*AW +: AW];
      chk("rd_after_edge", rd_data[k*DW +: DW], mdl[a]);
    end
    chk("pc_after_edge", pc_out, mdl[PCI]);
  endtask

  task automatic wr0(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1'b1, 1'b1, a, d, 1'b0, 4'd0, 32'd0, 1'b0, {a, a, a});
  endtask

  task automatic peek(input logic [AW-1:0] a, output logic [DW-1:0] v);
    rd_addr = {a, a, a};
    #1;
    v = rd_data[DW-1:0];
  endtask

  task automatic check_all();
    logic [AW-1:0] a;
    for (int i = 0; i < NR; i++) begin
      a = AW'(i);
      rd_addr = {a + 4'd2, a + 4'd1, a};
      #1;
      for (int k = 0; k < RP; k++)
        chk("rd_all", rd_data[k*DW +: DW], mdl[AW'(i + k)]);
    end
  endtask

  initial begin
    logic [DW-1:0] v;
    logic [AW-1:0] ra0, ra1;
    logic          rclr, re0, re1, rinc;

    // Power-up reset
    idle(); Clr = 1'b0; rd_addr = '0;
    wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
    @(posedge Clk); @(posedge Clk); #1;
    idle();
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    check_all();
    chk("pc_reset", pc_out, 32'd0);

    // Fill, then a single reset cycle clears everything
    for (int i = 0; i < NR; i++) wr0(AW'(i), 32'hA5A5_0000 + DW'(i));
    check_all();
    step(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, {4'd1, 4'd15, 4'd3});
    check_all();
    chk("pc_after_clr", pc_out, 32'd0);

    // Basic write/read
    wr0(4'd3, 32'h0000_0010);
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, {4'd3, 4'd3, 4'd0});
    wr0(4'd8, 32'h0000_0020);
    wr0(4'd3, 32'h0000_0099);
    peek(4'd8, v); chk("r8_kept", v, 32'h0000_0020);
    peek(4'd3, v); chk("r3_rewrite", v, 32'h0000_0099);

    // Collisions
    step(1'b1, 1'b1, 4'd5, 32'h1111_1111, 1'b1, 4'd5, 32'h2222_2222, 1'b0, {4'd5, 4'd5, 4'd5});
    peek(4'd5, v); chk("coll_r5", v, 32'h1111_1111);
    step(1'b1, 1'b1, 4'd7, 32'h0000_0044, 1'b1, 4'd6, 32'h0000_0033, 1'b0, {4'd7, 4'd6, 4'd5});
    peek(4'd6, v); chk("wr1_r6", v, 32'h0000_0033);
    peek(4'd7, v); chk("wr0_r7", v, 32'h0000_0044);

    // PC increment, write-over-increment, wrap
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, {4'd15, 4'd0, 4'd15});
    chk("pc_inc3", pc_out, 32'd12);
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'h0000_0100, 1'b1, {4'd15, 4'd15, 4'd15});
    chk("pc_wr1_wins", pc_out, 32'h0000_0100);
    wr0(4'd15, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, {4'd15, 4'd2, 4'd15});
    chk("pc_wrap", pc_out, 32'd0);

    // Bypass: same-cycle value depends on build, next cycle always the new value
    wr0(4'd2, 32'h0000_0077);
    @(negedge Clk);
    wr0_en = 1'b1; wr0_addr = 4'd2; wr0_data = 32'h0000_DEAD; rd_addr = {4'd0, 4'd0, 4'd2};
    #1;
    chk("bypass_same", rd_data[DW-1:0], BYP ? 32'h0000_DEAD : 32'h0000_0077);
    calc_next();
    @(posedge Clk);
    mdl = nxt_m;
    #1; idle(); #1;
    chk("bypass_next", rd_data[DW-1:0], 32'h0000_DEAD);

    // Reset with a write and increment pending
    step(1'b0, 1'b1, 4'd1, 32'h0000_0055, 1'b0, 4'd0, 32'd0, 1'b1, {4'd15, 4'd2, 4'd1});
    peek(4'd1, v); chk("clr_r1", v, 32'd0);
    chk("clr_pc", pc_out, 32'd0);

    // Random traffic, biased toward collisions and PC writes
    for (int n = 0; n < 400; n++) begin
      rclr = ($urandom_range(0, 29) != 0);
      re0  = $urandom_range(0, 1) == 1;
      re1  = $urandom_range(0, 1) == 1;
      rinc = $urandom_range(0, 1) == 1;
      ra0  = ($urandom_range(0, 3) == 0) ? 4'd15 : AW'($urandom_range(0, NR - 1));
      ra1  = ($urandom_range(0, 3) == 0) ? ra0 : AW'($urandom_range(0, NR - 1));
      step(rclr, re0, ra0, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : DW'($urandom),
           re1, ra1, DW'($urandom), rinc,
           {ra1, AW'($urandom_range(0, NR - 1)), ra0});
    end
    check_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
